pipelined_barrel_shifter: RTL and testbench

Pipelined, flow-controlled shifter/rotator for WIDTH-bit vectors. It performs rotate, logical shift or arithmetic shift, in either direction, with one mux level per register stage. The block sustains one operation per cycle under valid/ready backpressure. It sits in datapaths that need a high-frequency shift unit, such as ALUs, FP normalisation and packet realignment, where a single-cycle combinational rotator cannot close timing.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 27 ++
 rtl/pipelined_barrel_shifter_stage.sv | 132 +++++++++++++
 rtl/pipelined_barrel_shifter.sv | 87 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings,
// direction constants and the ceil(log2) helper used to size the pipeline.
// No ports; imported by the stage and top modules.
package pipelined_barrel_shifter_pkg;

  // Operation select carried alongside each operand through the pipeline.
  typedef enum logic [1:0] {
    ROTATE           = 2'd0,
    SHIFT_LOGICAL    = 2'd1,
    SHIFT_ARITHMETIC = 2'd2,
    RESERVED         = 2'd3   // treated exactly like SHIFT_LOGICAL
  } mode_e;

  localparam logic RIGHT = 1'b0;
  localparam logic LEFT  = 1'b1;

  // Smallest r with 2**r >= n (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One pipeline stage: conditionally moves the operand by SHIFT positions, then registers it.
// Latency 1 cycle; the stage loads when it is empty or when downstream drains it in the same cycle.
// Backpressure: up_rdy_o = !valid || dn_rdy_i, so stalls propagate upstream and bubbles collapse.
// Ports: clock/reset; up_* = operand, amount, mode, direction from the previous stage;
// dn_* = registered result to the next stage. Sticky ports exist only with
// PIPELINED_BARREL_SHIFTER_STICKY_EN defined.
module pipelined_barrel_shifter_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_vld_i,
  output logic             up_rdy_o,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [AMT_W-1:0] up_amt_i,
  input  logic [1:0]       up_mode_i,
  input  logic             up_left_i,
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  input  logic             up_sticky_i,
  output logic             dn_sticky_o,
`endif
  input  logic             dn_rdy_i,
  output logic             dn_vld_o,
  output logic [WIDTH-1:0] dn_data_o,
  output logic [AMT_W-1:0] dn_amt_o,
  output logic [1:0]       dn_mode_o,
  output logic             dn_left_o
);

  // Amount bit that enables this stage's move.
  localparam int BIT = clog2(SHIFT);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [1:0]       mode_q, mode_d;
  logic             left_q, left_d;

  logic [WIDTH-1:0] moved;
  logic             fill;
  logic             load;

  assign up_rdy_o = !vld_q || dn_rdy_i;
  assign load     = up_rdy_o && up_vld_i;

  // SHIFT is always < WIDTH, so every slice below is non-empty. Composing
  // the per-stage moves yields rotation by (amount mod WIDTH) and natural
  // saturation for shifts whose total amount reaches WIDTH.
  always_comb begin
    moved = up_data_i;
    fill  = 1'b0;
    if (up_amt_i[BIT]) begin
      if (up_mode_i == ROTATE) begin
        if (up_left_i == LEFT) begin
          moved = {up_data_i[WIDTH-SHIFT-1:0], up_data_i[WIDTH-1:WIDTH-SHIFT]};
        end else begin
          moved = {up_data_i[SHIFT-1:0], up_data_i[WIDTH-1:SHIFT]};
        end
      end else if (up_left_i == LEFT) begin
        // Arithmetic left is identical to logical left.
        moved = {up_data_i[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
      end else begin
        // Earlier stages already replicated the sign, so the current MSB is
        // still the operand's original MSB.
        fill  = (up_mode_i == SHIFT_ARITHMETIC) && up_data_i[WIDTH-1];
        moved = {{SHIFT{fill}}, up_data_i[WIDTH-1:SHIFT]};
      end
    end
  end

  assign vld_d  = up_rdy_o ? up_vld_i : vld_q;
  assign data_d = load ? moved     : data_q;
  assign amt_d  = load ? up_amt_i  : amt_q;
  assign mode_d = load ? up_mode_i : mode_q;
  assign left_d = load ? up_left_i : left_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      amt_q  <= '0;
      mode_q <= 2'd0;
      left_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      amt_q  <= amt_d;
      mode_q <= mode_d;
      left_q <= left_d;
    end
  end

  assign dn_vld_o  = vld_q;
  assign dn_data_o = data_q;
  assign dn_amt_o  = amt_q;
  assign dn_mode_o = mode_q;
  assign dn_left_o = left_q;

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  logic stk_q, stk_d;
  logic lost;

  // OR of the bits this stage pushes off the end; rotates never lose bits.
  always_comb begin
    lost = 1'b0;
    if (up_amt_i[BIT] && (up_mode_i != ROTATE)) begin
      if (up_left_i == LEFT) begin
        lost = |up_data_i[WIDTH-1:WIDTH-SHIFT];
      end else begin
        lost = |up_data_i[SHIFT-1:0];
      end
    end
  end

  assign stk_d = load ? (up_sticky_i | lost) : stk_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stk_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
    end
  end

  assign dn_sticky_o = stk_q;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate / logical / arithmetic shifter, one mux level per register stage.
// Latency WIDTH_LOG2 cycles from input handshake to out_valid; 1 op/cycle sustained.
// Backpressure: valid/ready chain; in_ready = stage-0 empty or draining, full pipe + !out_ready stalls input.
// Ports: clock, reset (async, active-high); in_valid/in_ready/in_data/in_amount/in_mode/in_left;
// out_valid/out_ready/out_data, plus out_sticky when PIPELINED_BARREL_SHIFTER_STICKY_EN is defined.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int WIDTH_LOG2 = clog2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [WIDTH_LOG2-1:0] in_amount,
  input  logic [1:0]            in_mode,
  input  logic                  in_left,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  output logic                  out_sticky,
`endif
  output logic [WIDTH-1:0]      out_data
);

  // Index k is the input side of stage k; index WIDTH_LOG2 is the output side.
  logic [WIDTH_LOG2:0]                 vld_w;
  logic [WIDTH_LOG2:0]                 rdy_w;
  logic [WIDTH_LOG2:0]                 left_w;
  logic [WIDTH_LOG2:0][WIDTH-1:0]      data_w;
  logic [WIDTH_LOG2:0][WIDTH_LOG2-1:0] amt_w;
  logic [WIDTH_LOG2:0][1:0]            mode_w;
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  logic [WIDTH_LOG2:0]                 stk_w;
  assign stk_w[0] = 1'b0;
`endif

  assign vld_w[0]  = in_valid;
  assign data_w[0] = in_data;
  assign amt_w[0]  = in_amount;
  assign mode_w[0] = in_mode;
  assign left_w[0] = in_left;

  // Ready chain runs combinationally from out_ready back to in_ready.
  assign rdy_w[WIDTH_LOG2] = out_ready;
  assign in_ready          = rdy_w[0];

  for (genvar k = 0; k < WIDTH_LOG2; k++) begin : g_stage
    pipelined_barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k),
      .AMT_W (WIDTH_LOG2)
    ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .up_vld_i    (vld_w[k]),
      .up_rdy_o    (rdy_w[k]),
      .up_data_i   (data_w[k]),
      .up_amt_i    (amt_w[k]),
      .up_mode_i   (mode_w[k]),
      .up_left_i   (left_w[k]),
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
      .up_sticky_i (stk_w[k]),
      .dn_sticky_o (stk_w[k+1]),
`endif
      .dn_rdy_i    (rdy_w[k+1]),
      .dn_vld_o    (vld_w[k+1]),
      .dn_data_o   (data_w[k+1]),
      .dn_amt_o    (amt_w[k+1]),
      .dn_mode_o   (mode_w[k+1]),
      .dn_left_o   (left_w[k+1])
    );
  end

  assign out_valid = vld_w[WIDTH_LOG2];
  assign out_data  = data_w[WIDTH_LOG2];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  assign out_sticky = stk_w[WIDTH_LOG2];
`endif

  // Control fields leaving the last stage have no consumer.
  logic [WIDTH_LOG2+2:0] last_ctrl_unused;
  assign last_ctrl_unused = {amt_w[WIDTH_LOG2], mode_w[WIDTH_LOG2], left_w[WIDTH_LOG2]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH = 8).
// Expected results are queued at input handshake and popped at output handshake.
// Covers reset, fixed vectors, random stream, backpressure hold and mid-flight reset.
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  localparam int W = 8;
  localparam int L = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [L-1:0] in_amount;
  logic [1:0]   in_mode;
  logic         in_left;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  logic         out_sticky;
`endif

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_mode   (in_mode),
    .in_left   (in_left),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    .out_sticky(out_sticky),
`endif
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         sticky;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit-level reference: returns {sticky, data}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] d, input int a,
                                        input int m, input bit lft);
    logic [W-1:0] r;
    logic         st;
    st = 1'b0;
    r  = '0;
    if (m == 0) begin
      for (int i = 0; i < W; i++) begin
        if (lft) r[(i + a) % W] = d[i];
        else     r[i] = d[(i + a) % W];
      end
    end else begin
      r = (m == 2 && !lft && d[W-1]) ? '1 : '0;
      for (int i = 0; i < W; i++) begin
        if (lft) begin
          if (i + a < W) r[i + a] = d[i];
          else           st = st | d[i];
        end else begin
          if (i - a >= 0) r[i - a] = d[i];
          else            st = st | d[i];
        end
      end
    end
    return {st, r};
  endfunction

  // Output side: every output handshake must match the oldest queued result.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      chk("result_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
        chk("out_sticky", 32'(out_sticky), 32'(e.sticky));
`endif
        if (e.chk_lat) chk("latency", 32'(cyc - e.acc_cyc), L);
      end
    end
  end

  // Drive one operation and hold it until accepted; waits = stalled cycles.
  task automatic send(input logic [W-1:0] d, input int a, input int m, input bit lft,
                      input logic [W-1:0] ed, input logic es, input bit lat,
                      output int waits);
    exp_t e;
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = L'(a);
    in_mode   = 2'(m);
    in_left   = lft;
    waits     = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      waits = waits + 1;
      if (waits > 100) break;
    end
    if (in_ready) begin
      e.data = ed; e.sticky = es; e.acc_cyc = cyc; e.chk_lat = lat;
      sb.push_back(e);
    end else begin
      chk("accept_timeout", 32'(in_ready), 1);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] d, input int a, input int m,
                            input bit lft, input bit lat, output int waits);
    logic [W:0] r;
    r = ref_op(d, a, m, lft);
    send(d, a, m, lft, r[W-1:0], r[W], lat, waits);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n = n + 1;
    end
    chk("drain_left", 32'(sb.size()), 0);
    @(posedge clock);
    #1;
  endtask

  // Fixed vectors on 0x96: mode, amount, left, expected data, expected sticky.
  // Logical left 3 drops bits 3'b100, so sticky is set there.
  int           fx_mode [6] = '{0, 0, 1, 1, 2, 2};
  int           fx_amt  [6] = '{3, 3, 3, 3, 3, 7};
  bit           fx_left [6] = '{0, 1, 0, 1, 0, 0};
  logic [W-1:0] fx_data [6] = '{8'hD2, 8'hB4, 8'h12, 8'hB0, 8'hF2, 8'hFF};
  logic         fx_stk  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int           w;
    int           seen;
    logic [W-1:0] hold;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amount = '0;
    in_mode = 2'd0; in_left = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    chk("rst_out_sticky", 32'(out_sticky), 0);
`endif
    reset = 1'b0;

    // Fixed vectors, back to back.
    for (int i = 0; i < 6; i++)
      send(8'h96, fx_amt[i], fx_mode[i], fx_left[i], fx_data[i], fx_stk[i], 1'b1, w);
    wait_drain();

    // Random stream: every op accepted on its first cycle, results consecutive.
    for (int i = 0; i < 16; i++) begin
      send_model(W'($urandom), $urandom_range(0, L'(W - 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'b1, w);
      chk("stream_in_ready_waits", 32'(w), 0);
    end
    wait_drain();

    // Backpressure: fill all stages with out_ready low, then hold 5 cycles.
    out_ready = 1'b0;
    send_model(8'h96, 1, 1, 1'b0, 1'b0, w);
    send_model(8'h3C, 2, 0, 1'b1, 1'b0, w);
    send_model(8'hA5, 5, 2, 1'b0, 1'b0, w);
    @(negedge clock);
    chk("bp_in_ready_full", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_head_data", 32'(out_data), 32'(sb[0].data));
    hold = out_data;
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_data", 32'(out_data), 32'(hold));
      chk("bp_hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    // A full pipe draining must take a new input in the same cycle.
    send_model(8'h81, 7, 1, 1'b1, 1'b0, w);
    chk("full_drain_accept_waits", 32'(w), 0);
    send_model(8'h81, 4, 2, 1'b0, 1'b0, w);
    wait_drain();

    // Reset with two operations in flight.
    send_model(8'h96, 3, 0, 1'b0, 1'b1, w);
    send_model(8'h96, 3, 1, 1'b1, 1'b1, w);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid) seen = seen + 1;
    end
    chk("post_rst_stale_outputs", 32'(seen), 0);
    @(posedge clock);
    #1;
    send_model(8'h96, 3, 2, 1'b0, 1'b1, w);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
